// File: rtl/imem_fetch_arbiter_if.sv
// Handshake and memory-port bundle between the fetch stage, the loader,
// the fetch arbiter and the byte-wide instruction memory.
interface imem_fetch_arbiter_if #(
  parameter int DW    = 32,
  parameter int ADDRW = 9
);
  logic             fetch_req;
  logic [DW-1:0]    fetch_addr;
  logic             fetch_ready;
  logic [DW-1:0]    instr;
  logic             instr_valid;
  logic             instr_err;
  logic             instr_ready;
  logic             load_valid;
  logic [ADDRW-1:0] load_addr;
  logic [7:0]       load_data;
  logic             load_ready;
  logic [ADDRW-1:0] mem_addr;
  logic             mem_we;
  logic [7:0]       mem_wdata;
  logic [7:0]       mem_rdata;
  logic             busy;

  modport slave (
    input  fetch_req, fetch_addr, instr_ready, load_valid, load_addr, load_data, mem_rdata,
    output fetch_ready, instr, instr_valid, instr_err, load_ready, mem_addr, mem_we, mem_wdata, busy
  );

  modport master (
    output fetch_req, fetch_addr, instr_ready, load_valid, load_addr, load_data, mem_rdata,
    input  fetch_ready, instr, instr_valid, instr_err, load_ready, mem_addr, mem_we, mem_wdata, busy
  );
endinterface

// File: rtl/imem_fetch_arbiter.sv
// Shares a single-port byte-wide instruction memory between the core fetch path
// (4-byte big-endian instruction reads) and the program loader (byte writes).
module imem_fetch_arbiter #(
  parameter int NUMOFINST = 120,
  parameter int DW        = 32,
  parameter int WORDS     = NUMOFINST * 4,
  parameter int ADDRW     = $clog2(WORDS)
) (
  input  logic clk,
  input  logic rst_n,
  imem_fetch_arbiter_if.slave bus
);
  localparam logic [DW-1:0] NOP = DW'(32'h0000_0013);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, RESP} state_t;
  typedef enum logic {G_FETCH, G_LOAD} grant_t;

  state_t           state;
  grant_t           last_grant;
  logic [2:0]       cnt;
  logic [DW-9:0]    sh;
  logic             fetch_win, load_win, in_range;
  logic [DW:0]      end_addr;

  // On contention the requester that did not win last time goes first.
  always_comb begin
    fetch_win = bus.fetch_req && (!bus.load_valid || last_grant == G_LOAD);
    load_win  = bus.load_valid && !fetch_win;
    end_addr  = {1'b0, bus.fetch_addr} + (DW+1)'(3);
    in_range  = end_addr < (DW+1)'(WORDS);
  end

  assign bus.fetch_ready = rst_n && (state == IDLE) && fetch_win;
  assign bus.load_ready  = rst_n && (state == IDLE) && load_win;
  assign bus.busy        = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      last_grant      <= G_LOAD;
      cnt             <= '0;
      sh              <= '0;
      bus.instr       <= '0;
      bus.instr_valid <= 1'b0;
      bus.instr_err   <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_we      <= 1'b0;
      bus.mem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fetch_win) begin
            last_grant <= G_FETCH;
            cnt        <= '0;
            if (in_range) begin
              bus.mem_addr <= bus.fetch_addr[ADDRW-1:0];
              state        <= FETCH;
            end else begin
              bus.instr       <= NOP;
              bus.instr_err   <= 1'b1;
              bus.instr_valid <= 1'b1;
              state           <= RESP;
            end
          end else if (load_win) begin
            last_grant    <= G_LOAD;
            bus.mem_addr  <= bus.load_addr;
            bus.mem_wdata <= bus.load_data;
            bus.mem_we    <= 1'b1;
            state         <= LOAD;
          end
        end
        // Addresses go out on cnt 0..3, bytes return one cycle later on cnt 1..4.
        FETCH: begin
          cnt <= cnt + 3'd1;
          if (cnt < 3'd3) bus.mem_addr <= bus.mem_addr + ADDRW'(1);
          if (cnt != 3'd0) sh <= {sh[DW-17:0], bus.mem_rdata};
          if (cnt == 3'd4) begin
            bus.instr       <= {sh, bus.mem_rdata};
            bus.instr_err   <= 1'b0;
            bus.instr_valid <= 1'b1;
            state           <= RESP;
          end
        end
        LOAD: begin
          bus.mem_we <= 1'b0;
          state      <= IDLE;
        end
        RESP: begin
          if (bus.instr_ready) begin
            bus.instr_valid <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
